output_row_scheduler: RTL and testbench

- Grant controller in front of the double-buffered output collector.
- Accepts per-set "result ready" requests from the OUT_NUM_OF_SET adder trees and issues the adder_valid grant mask that the collector consumes.
- Never grants rows the collector's two KERNEL_SIZE-row buffers cannot hold.
- Presents completed buffers to the downstream consumer with a valid/ready handshake and counts a layer to completion.

---
 rtl/output_row_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_output_row_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_row_scheduler.sv
// -----------------------------------------------------------------------------
// output_row_scheduler
//
// Grant controller in front of the double-buffered output collector. Each
// adder set raises a request when it holds a finished row. The block grants
// up to OUT_NUM_OF_SET rows per cycle, and never more than the two
// KERNEL_SIZE-row collector buffers can absorb. Completed buffers are offered
// downstream with a valid/ready handshake. A layer of num_sets buffers is
// counted to completion, and the end of the layer is flagged with a done pulse.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   start        begins a layer (sampled only while idle)
//   num_sets     buffers in the layer, captured on start (0 = finish at once)
//   adder_req    per-set "row ready" requests, held until granted
//   adder_valid  grant mask (combinational from registered state + adder_req)
//   out_valid    a completed buffer is on offer
//   out_sel      index of the buffer on offer
//   out_ready    consumer takes the offered buffer
//   busy         layer in progress (RUN or DRAIN)
//   done         one-cycle end-of-layer pulse
// -----------------------------------------------------------------------------
module output_row_scheduler #(
    parameter int KERNEL_SIZE    = 9,
    parameter int OUT_NUM_OF_SET = 3,
    parameter int SET_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SET_CNT_WIDTH-1:0]  num_sets,
    input  logic [OUT_NUM_OF_SET-1:0] adder_req,
    output logic [OUT_NUM_OF_SET-1:0] adder_valid,
    output logic                      out_valid,
    output logic                      out_sel,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int RL_W   = SET_CNT_WIDTH + $clog2(KERNEL_SIZE) + 1;
    localparam int FILL_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int PTR_W  = (OUT_NUM_OF_SET > 1) ? $clog2(OUT_NUM_OF_SET) : 1;
    localparam logic [RL_W-1:0]  K_RL     = RL_W'(KERNEL_SIZE);
    localparam logic [RL_W-1:0]  N_RL     = RL_W'(OUT_NUM_OF_SET);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_NUM_OF_SET - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r,     state_s;
    logic [FILL_W-1:0]   fill_rows_r, fill_rows_s;
    logic [1:0]          full_cnt_r,  full_cnt_s;
    logic [RL_W-1:0]     rows_left_r, rows_left_s;
    logic [PTR_W-1:0]    rr_ptr_r,    rr_ptr_s;
    logic                out_valid_r;
    logic                out_sel_r;
    logic                busy_r;
    logic                done_r;

    logic [RL_W-1:0]           space_s;
    logic [RL_W-1:0]           cap_s;
    logic [RL_W-1:0]           grant_cnt_s;
    logic [RL_W-1:0]           fill_sum_s;
    logic [OUT_NUM_OF_SET-1:0] grant_s;
    logic [PTR_W-1:0]          last_idx_s;
    logic                      cap_limited_s;
    logic                      handshake_s;
    logic                      buf_complete_s;

    function automatic logic [RL_W-1:0] popcount(input logic [OUT_NUM_OF_SET-1:0] v);
        logic [RL_W-1:0] c;
        c = '0;
        for (int i = 0; i < OUT_NUM_OF_SET; i++) begin
            c = c + RL_W'(v[i]);
        end
        return c;
    endfunction

    // Grant capacity and rotating-priority scan of the requests
    always_comb begin : grant_scan
        logic [PTR_W-1:0] idx;
        // Free rows across both buffers: empty buffers minus the partial fill.
        space_s = (RL_W'(2'd2) - RL_W'(full_cnt_r)) * K_RL - RL_W'(fill_rows_r);
        cap_s   = space_s;
        if (rows_left_r < cap_s) begin
            cap_s = rows_left_r;
        end else begin
            cap_s = cap_s;
        end
        if (N_RL < cap_s) begin
            cap_s = N_RL;
        end else begin
            cap_s = cap_s;
        end
        if (state_r != ST_RUN) begin
            cap_s = '0;
        end else begin
            cap_s = cap_s;
        end

        grant_s     = '0;
        grant_cnt_s = '0;
        last_idx_s  = rr_ptr_r;
        idx         = rr_ptr_r;
        for (int k = 0; k < OUT_NUM_OF_SET; k++) begin
            idx = PTR_W'((int'(rr_ptr_r) + k) % OUT_NUM_OF_SET);
            if (adder_req[idx] && (grant_cnt_s < cap_s)) begin
                grant_s[idx] = 1'b1;
                grant_cnt_s  = grant_cnt_s + RL_W'(1'b1);
                last_idx_s   = idx;
            end else begin
                grant_cnt_s = grant_cnt_s;
            end
        end
        // Pointer only rotates when some requester was left waiting for space.
        cap_limited_s = (grant_cnt_s != '0) && (popcount(adder_req) > grant_cnt_s);
    end

    assign adder_valid = grant_s;

    // Next-state: buffer occupancy, layer row count, priority pointer, FSM
    always_comb begin
        state_s     = state_r;
        rows_left_s = rows_left_r;
        full_cnt_s  = full_cnt_r;
        rr_ptr_s    = rr_ptr_r;
        handshake_s = out_valid_r & out_ready;

        fill_sum_s     = RL_W'(fill_rows_r) + grant_cnt_s;
        buf_complete_s = (fill_sum_s >= K_RL);
        if (buf_complete_s) begin
            fill_rows_s = FILL_W'(fill_sum_s - K_RL);
        end else begin
            fill_rows_s = FILL_W'(fill_sum_s);
        end

        case ({buf_complete_s, handshake_s})
            2'b10:   full_cnt_s = full_cnt_r + 2'd1;
            2'b01:   full_cnt_s = full_cnt_r - 2'd1;
            default: full_cnt_s = full_cnt_r;
        endcase

        if (cap_limited_s) begin
            rr_ptr_s = (last_idx_s == LAST_PTR) ? '0 : last_idx_s + PTR_W'(1'b1);
        end else begin
            rr_ptr_s = rr_ptr_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_sets != '0) begin
                        state_s     = ST_RUN;
                        rows_left_s = RL_W'(num_sets) * K_RL;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                rows_left_s = rows_left_r - grant_cnt_s;
                if (rows_left_s == '0) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (full_cnt_r == 2'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            fill_rows_r <= '0;
            full_cnt_r  <= 2'd0;
            rows_left_r <= '0;
            rr_ptr_r    <= '0;
            out_valid_r <= 1'b0;
            out_sel_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            fill_rows_r <= fill_rows_s;
            full_cnt_r  <= full_cnt_s;
            rows_left_r <= rows_left_s;
            rr_ptr_r    <= rr_ptr_s;
            out_valid_r <= (full_cnt_s != 2'd0);
            out_sel_r   <= out_sel_r ^ handshake_s;
            busy_r      <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
            done_r      <= (state_s == ST_DONE);
        end
    end

    assign out_valid = out_valid_r;
    assign out_sel   = out_sel_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_output_row_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for output_row_scheduler. The reference model tracks rows in
// aggregate terms: total rows granted, rows stored in the collector and rows
// left in the layer. It predicts the grant mask and the status outputs every
// cycle. Each completed buffer pushes its expected out_sel into a scoreboard
// queue, and a separate monitor pops that queue on every handshake.
// -----------------------------------------------------------------------------
module tb_output_row_scheduler;

    localparam int K  = 9;
    localparam int N  = 3;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] num_sets = '0;
    logic [N-1:0]  adder_req = '0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  adder_valid;
    logic          out_valid;
    logic          out_sel;
    logic          busy;
    logic          done;

    output_row_scheduler #(.KERNEL_SIZE(K), .OUT_NUM_OF_SET(N), .SET_CNT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_sets(num_sets),
        .adder_req(adder_req), .adder_valid(adder_valid), .out_valid(out_valid),
        .out_sel(out_sel), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_sel_q[$];

    // model: phase 0 idle, 1 granting, 2 draining, 3 finishing
    int m_phase, m_left, m_stored, m_rr, m_tg;
    logic [N-1:0] e_grant;
    int   e_last;
    logic e_ov, e_busy, e_done;

    int req_mode;   // 0: all sets requesting, 1: random held requests, 2: manual
    int rdy_mode;   // 0: manual out_ready, 1: random
    int n_full_grants, n_done, n_hs;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_stored = 0; m_rr = 0; m_tg = 0;
        exp_sel_q.delete();
    endtask

    task automatic model_eval();
        int cap, cnt, idx;
        e_grant = '0;
        e_last  = m_rr;
        e_busy  = (m_phase == 1) || (m_phase == 2);
        e_done  = (m_phase == 3);
        e_ov    = (m_stored >= K);
        if (m_phase == 1) begin
            cap = 2 * K - m_stored;
            if (m_left < cap) cap = m_left;
            if (N < cap) cap = N;
            cnt = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (adder_req[idx] && cnt < cap) begin
                    e_grant[idx] = 1'b1;
                    cnt++;
                    e_last = idx;
                end
            end
        end
    endtask

    task automatic model_commit();
        int g, reqs, old_b;
        g    = $countones(e_grant);
        reqs = $countones(adder_req);
        if (g > 0 && reqs > g) m_rr = (e_last + 1) % N;
        old_b = m_tg / K;
        m_tg  = m_tg + g;
        if (m_tg / K != old_b) exp_sel_q.push_back((m_tg / K - 1) % 2);
        m_stored = m_stored + g;
        m_left   = m_left - g;
        if (e_ov && out_ready) m_stored = m_stored - K;
        case (m_phase)
            0: if (start) begin
                   if (num_sets != '0) begin
                       m_left  = int'(num_sets) * K;
                       m_phase = 1;
                   end else begin
                       m_phase = 3;
                   end
               end
            1: if (m_left == 0) m_phase = 2;
            2: if (!e_ov) m_phase = 3;
            default: m_phase = 0;
        endcase
    endtask

    task automatic cycle();
        logic [N-1:0] r;
        #1;
        model_eval();
        check("adder_valid", int'(adder_valid), int'(e_grant));
        check("out_valid", int'(out_valid), int'(e_ov));
        check("busy", int'(busy), int'(e_busy));
        check("done", int'(done), int'(e_done));
        model_commit();
        @(posedge clk);
        @(negedge clk);
        if (req_mode == 0) begin
            adder_req = 3'b111;
        end else if (req_mode == 1) begin
            r = 3'($urandom & $urandom);
            adder_req = (adder_req & ~e_grant) | r;
        end
        if (rdy_mode == 1) out_ready = 1'($urandom);
    endtask

    task automatic start_layer(input int n);
        num_sets = SW'(n);
        start    = 1'b1;
        cycle();
        start    = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int c = 0;
        while (m_phase != 0 && c < budget) begin
            cycle();
            c++;
        end
        if (m_phase != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL layer_timeout: still busy after %0d cycles", budget);
        end
    endtask

    task automatic reset_now(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_adder_valid"}, int'(adder_valid), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_sel"}, int'(out_sel), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every handshake and counts events
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (adder_valid == 3'b111) n_full_grants++;
            if (done) n_done++;
            if (out_valid && out_ready) begin
                n_hs++;
                if (exp_sel_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_handshake: out_sel=%0d with no buffer expected", out_sel);
                end else begin
                    check("out_sel", int'(out_sel), exp_sel_q.pop_front());
                end
            end
        end
    end

    initial begin
        req_mode = 0; rdy_mode = 0;
        n_full_grants = 0; n_done = 0; n_hs = 0;
        model_reset();
        reset_now("reset");

        // 1: single buffer, everything ready
        out_ready = 1'b1; adder_req = 3'b111;
        n_full_grants = 0; n_done = 0;
        start_layer(1);
        run_until_idle(50);
        check("t1_full_grants", n_full_grants, 3);
        check("t1_done_pulses", n_done, 1);

        // 2: consumer stalled, both buffers fill, then drain
        out_ready = 1'b0; n_full_grants = 0;
        start_layer(3);
        for (int i = 0; i < 6; i++) cycle();
        #1;
        check("t2_stall_grant", int'(adder_valid), 0);
        check("t2_full_grants", n_full_grants, 6);
        cycle();
        out_ready = 1'b1;
        run_until_idle(100);

        // 3: capacity-limited single grant rotates the pointer
        out_ready = 1'b0; req_mode = 2; adder_req = 3'b111;
        start_layer(3);
        for (int i = 0; i < 5; i++) cycle();
        adder_req = 3'b011;
        cycle();
        adder_req = 3'b111;
        #1;
        check("t3_cap_one", int'(adder_valid), 1);
        cycle();
        cycle();
        cycle();
        out_ready = 1'b1; req_mode = 0;
        run_until_idle(100);

        // 4: last row of a layer granted alone
        adder_req = 3'b111; req_mode = 2;
        start_layer(1);
        cycle();
        cycle();
        adder_req = 3'b011;
        cycle();
        adder_req = 3'b111;
        #1;
        check("t4_one_bit", $countones(adder_valid), 1);
        cycle();
        req_mode = 0;
        run_until_idle(50);

        // 5: reset mid-layer with one full buffer pending
        out_ready = 1'b0;
        start_layer(3);
        for (int i = 0; i < 4; i++) cycle();
        reset_now("t5_reset");
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        start_layer(1);
        run_until_idle(50);

        // 6: start during a layer is ignored
        n_hs = 0;
        start_layer(2);
        cycle();
        cycle();
        num_sets = SW'(5); start = 1'b1;
        cycle();
        start = 1'b0;
        run_until_idle(100);
        check("t6_handshakes", n_hs, 2);

        // zero-length layer
        n_done = 0;
        start_layer(0);
        run_until_idle(10);
        check("zero_layer_done", n_done, 1);

        // randomized layers
        req_mode = 1; rdy_mode = 1;
        for (int l = 0; l < 10; l++) begin
            start_layer($urandom_range(0, 4));
            run_until_idle(1500);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) cycle();
        end

        check("scoreboard_empty", exp_sel_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
